// File: rtl/boot_loader_pkg.sv
// boot_loader_pkg: shared state encoding and widths for the ROM boot loader
package boot_loader_pkg;
  typedef enum logic [1:0] {LOAD_BYTE, WRITE_WORD, DONE, ERROR} state_t;
  localparam int ADDR_WIDTH = 32;
  localparam int WORD_BYTES = 4;
endpackage

// File: rtl/byte_word_packer.sv
// byte_word_packer: lane-indexed byte insert into a 32-bit word with sync clear
module byte_word_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        load,
  input  logic [1:0]  lane,
  input  logic [7:0]  data,
  output logic [31:0] word
);
  always_ff @(posedge clk)
    if (rst || clear) word <= '0;
    else if (load) word[{lane, 3'b000} +: 8] <= data;
endmodule

// File: rtl/rom_boot_loader.sv
// rom_boot_loader: copies the ROM image into memory as little-endian words, then releases the CPU
module rom_boot_loader import boot_loader_pkg::*; #(
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDRESS = 32'd0,
  parameter int                    MAX_BYTES    = 65536
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] rom_address,
  input  logic [7:0]            rom_byte,
  input  logic                  rom_done,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [31:0]           mem_write_data,
  output logic                  mem_write_enable,
  input  logic                  mem_ready,
  output logic                  cpu_reset,
  output logic                  load_complete,
  output logic                  load_error
);
  state_t state, state_n;
  logic done_l, limit_l, at_limit, last, accept;
  assign at_limit = rom_address == ADDR_WIDTH'(MAX_BYTES - 1);
  assign last = rom_address[1:0] == 2'd3 || rom_done || at_limit;
  assign accept = state == WRITE_WORD && mem_ready;
  assign mem_write_enable = state == WRITE_WORD;
  assign cpu_reset = state != DONE;
  assign load_complete = state == DONE;
  assign load_error = state == ERROR;
  always_comb begin
    state_n = (state == LOAD_BYTE && last) ? WRITE_WORD :
              accept ? (done_l ? DONE : limit_l ? ERROR : LOAD_BYTE) : state;
  end
  always_ff @(posedge clk)
    if (reset) state <= LOAD_BYTE;
    else state <= state_n;
  // the final-byte flags are re-latched every byte; only the one that ends the word matters
  always_ff @(posedge clk)
    if (reset) begin
      rom_address <= '0;
      mem_address <= BASE_ADDRESS;
      done_l <= 1'b0;
      limit_l <= 1'b0;
    end else begin
      if (state == LOAD_BYTE) begin
        done_l <= rom_done;
        limit_l <= at_limit;
        if (!last) rom_address <= rom_address + 1'b1;
      end
      if (accept) begin
        mem_address <= mem_address + ADDR_WIDTH'(WORD_BYTES);
        if (!done_l && !limit_l) rom_address <= rom_address + 1'b1;
      end
    end
  byte_word_packer u_packer (
    .clk  (clk),
    .rst  (reset),
    .clear(accept),
    .load (state == LOAD_BYTE),
    .lane (rom_address[1:0]),
    .data (rom_byte),
    .word (mem_write_data)
  );
endmodule
